// File: rtl/udp_packet_fifo.sv
// Store-and-forward packet FIFO: a packet becomes visible to TX only once fully written;
// overflowing or truncated packets are rewound away atomically and counted.
module udp_packet_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_rx,
    output logic                ready_rx,
    input  logic                first_rx,
    input  logic                last_rx,
    input  logic [DATA_W-1:0]   payload_rx,
    input  logic [DATA_W/8-1:0] last_be_rx,
    output logic                valid_tx,
    input  logic                ready_tx,
    output logic                first_tx,
    output logic                last_tx,
    output logic [DATA_W-1:0]   payload_tx,
    output logic [DATA_W/8-1:0] last_be_tx,
    output logic [ADDR_W:0]     pkt_count,
    output logic [CNT_W-1:0]    drop_count,
    output logic [CNT_W-1:0]    err_count
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] payload;
        logic              first;
        logic              last;
        logic [BE_W-1:0]   be;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_SKIP} rx_state_t;

    rx_state_t        state;
    logic [PTR_W-1:0] wr;
    logic [PTR_W-1:0] cmt;
    logic [PTR_W-1:0] rd;
    entry_t           mem [DEPTH];
    entry_t           stage_q;
    logic             stage_v;

    logic             accept;
    logic             start;
    logic             cont;
    logic             room;
    logic             we;
    logic             overflow;
    logic             commit;
    logic             err_hit;
    logic [PTR_W-1:0] waddr;
    entry_t           wr_entry;
    logic             out_load;
    logic             stage_adv;
    logic             rd_issue;
    logic             tx_done;

    // A first word always restarts at cmt, so its room is measured from cmt, not wr.
    always_comb begin
        accept           = valid_rx & ready_rx;
        start            = accept & first_rx;
        cont             = accept & ~first_rx & (state == S_RECV);
        waddr            = start ? cmt : wr;
        room             = (waddr - rd) != PTR_W'(DEPTH);
        we               = (start | cont) & room;
        overflow         = (start | cont) & ~room;
        commit           = we & last_rx;
        err_hit          = accept & (first_rx ? (state == S_RECV) : (state == S_IDLE));
        wr_entry.payload = payload_rx;
        wr_entry.first   = first_rx;
        wr_entry.last    = last_rx;
        wr_entry.be      = last_rx ? last_be_rx : {BE_W{1'b1}};
        out_load         = ~valid_tx | ready_tx;
        stage_adv        = ~stage_v | out_load;
        rd_issue         = (rd != cmt) & stage_adv;
        tx_done          = valid_tx & ready_tx & last_tx;
    end

    // RX state machine, write/commit pointers and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr         <= '0;
            cmt        <= '0;
            ready_rx   <= 1'b0;
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            ready_rx <= 1'b1;
            if (we) begin
                wr <= waddr + PTR_W'(1);
            end else if (overflow) begin
                wr <= cmt;
            end
            if (commit) begin
                cmt <= waddr + PTR_W'(1);
            end
            if (overflow && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            if (err_hit && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (accept) begin
                if (we) begin
                    state <= last_rx ? S_IDLE : S_RECV;
                end else if (overflow) begin
                    state <= last_rx ? S_IDLE : S_DROP;
                end else if (last_rx) begin
                    state <= S_IDLE;
                end else if (state == S_IDLE) begin
                    state <= S_SKIP;
                end
            end
        end
    end

    // Storage array with one-cycle registered read
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr[ADDR_W-1:0]] <= wr_entry;
        end
        if (rd_issue) begin
            stage_q <= mem[rd[ADDR_W-1:0]];
        end
    end

    // TX pipeline: read stage feeding a registered output stage that holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            rd         <= '0;
            stage_v    <= 1'b0;
            valid_tx   <= 1'b0;
            first_tx   <= 1'b0;
            last_tx    <= 1'b0;
            payload_tx <= '0;
            last_be_tx <= {BE_W{1'b1}};
            pkt_count  <= '0;
        end else begin
            if (stage_adv) begin
                stage_v <= rd_issue;
                if (rd_issue) begin
                    rd <= rd + PTR_W'(1);
                end
            end
            if (out_load) begin
                valid_tx <= stage_v;
                first_tx <= stage_v & stage_q.first;
                last_tx  <= stage_v & stage_q.last;
                if (stage_v) begin
                    payload_tx <= stage_q.payload;
                    last_be_tx <= stage_q.be;
                end
            end
            case ({commit, tx_done})
                2'b10:   pkt_count <= pkt_count + PTR_W'(1);
                2'b01:   pkt_count <= pkt_count - PTR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_packet_fifo.sv
// Self-checking bench for udp_packet_fifo: directed scenarios plus randomized traffic
// checked against a packet-level queue model.
module tb_udp_packet_fifo;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_rx;
    logic        ready_rx;
    logic        first_rx;
    logic        last_rx;
    logic [31:0] payload_rx;
    logic [3:0]  last_be_rx;
    logic        valid_tx;
    logic        ready_tx;
    logic        first_tx;
    logic        last_tx;
    logic [31:0] payload_tx;
    logic [3:0]  last_be_tx;
    logic [9:0]  pkt_count;
    logic [15:0] drop_count;
    logic [15:0] err_count;

    typedef struct packed {
        logic [31:0] payload;
        logic        first;
        logic        last;
        logic [3:0]  be;
    } word_t;

    word_t exp_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    udp_packet_fifo #(.DATA_W(32), .ADDR_W(9), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .valid_rx(valid_rx), .ready_rx(ready_rx), .first_rx(first_rx), .last_rx(last_rx),
        .payload_rx(payload_rx), .last_be_rx(last_be_rx),
        .valid_tx(valid_tx), .ready_tx(ready_tx), .first_tx(first_tx), .last_tx(last_tx),
        .payload_tx(payload_tx), .last_be_tx(last_be_tx),
        .pkt_count(pkt_count), .drop_count(drop_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required normal finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid_rx = 1'b0; first_rx = 1'b0; last_rx = 1'b0;
        payload_rx = '0; last_be_rx = '0; ready_tx = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic drive_word(input logic f, input logic l, input logic [31:0] p, input logic [3:0] be);
        @(negedge clk);
        valid_rx = 1'b1; first_rx = f; last_rx = l; payload_rx = p; last_be_rx = be;
    endtask

    // Model: a well-formed packet is stored iff it fits beside everything not yet delivered.
    task automatic send_pkt(input int len, input logic [3:0] lbe, input int gap_pct, output bit committed);
        word_t w;
        word_t pkt[$];
        committed = (exp_q.size() + len <= DEPTH);
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                valid_rx = 1'b0;
            end
            w.payload = $urandom;
            w.first   = (i == 0);
            w.last    = (i == len - 1);
            w.be      = w.last ? lbe : 4'hF;
            drive_word(w.first, w.last, w.payload, w.last ? lbe : 4'($urandom));
            pkt.push_back(w);
        end
        if (committed) foreach (pkt[i]) exp_q.push_back(pkt[i]);
        @(negedge clk);
        valid_rx = 1'b0; first_rx = 1'b0; last_rx = 1'b0;
    endtask

    // mode 0: ready high, 1: alternating, 2: random ~70% high
    task automatic drain(input int n_words, input int mode, input int budget);
        int    got = 0;
        int    cyc = 0;
        bit    stalled = 1'b0;
        word_t prev = '0;
        word_t cur;
        word_t e;
        while (got < n_words && cyc < budget) begin
            @(negedge clk);
            cyc++;
            cur = {payload_tx, first_tx, last_tx, last_be_tx};
            if (stalled) begin
                tests_run++;
                if (valid_tx !== 1'b1 || cur !== prev) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got v=%b %h required v=1 %h", valid_tx, cur, prev);
                end
            end
            case (mode)
                0:       ready_tx = 1'b1;
                1:       ready_tx = cyc[0];
                default: ready_tx = (int'($urandom_range(99)) < 70);
            endcase
            if (valid_tx && ready_tx) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL drain_extra: got %h required no word", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        tests_failed++;
                        $display("FAIL drain_word: got %h required %h", cur, e);
                    end
                end
                got++;
            end
            stalled = valid_tx && !ready_tx;
            prev    = cur;
        end
        tests_run++;
        if (got != n_words) begin
            tests_failed++;
            $display("FAIL drain_count: got %0d words required %0d", got, n_words);
        end
        @(negedge clk);
        ready_tx = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++; if (ready_rx !== 1'b0) begin tests_failed++; $display("FAIL rst_ready_rx: got %b required 0", ready_rx); end
        tests_run++; if (valid_tx !== 1'b0) begin tests_failed++; $display("FAIL rst_valid_tx: got %b required 0", valid_tx); end
        tests_run++; if (first_tx !== 1'b0) begin tests_failed++; $display("FAIL rst_first_tx: got %b required 0", first_tx); end
        tests_run++; if (last_tx !== 1'b0) begin tests_failed++; $display("FAIL rst_last_tx: got %b required 0", last_tx); end
        tests_run++; if (payload_tx !== 32'h0) begin tests_failed++; $display("FAIL rst_payload: got %h required 0", payload_tx); end
        tests_run++; if (last_be_tx !== 4'hF) begin tests_failed++; $display("FAIL rst_be: got %h required f", last_be_tx); end
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL rst_pkt: got %0d required 0", pkt_count); end
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL rst_drop: got %0d required 0", drop_count); end
        tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL rst_err: got %0d required 0", err_count); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (ready_rx !== 1'b1) begin tests_failed++; $display("FAIL run_ready_rx: got %b required 1", ready_rx); end
    endtask

    task automatic test_basic();
        word_t exp_w[3];
        word_t cur;
        do_reset();
        ready_tx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_w[i].payload = $urandom;
            exp_w[i].first   = (i == 0);
            exp_w[i].last    = (i == 2);
            exp_w[i].be      = (i == 2) ? 4'b0011 : 4'b1111;
            drive_word(exp_w[i].first, exp_w[i].last, exp_w[i].payload, (i == 2) ? 4'b0011 : 4'b0101);
        end
        @(negedge clk);
        valid_rx = 1'b0; first_rx = 1'b0; last_rx = 1'b0;
        tests_run++; if (valid_tx !== 1'b0) begin tests_failed++; $display("FAIL basic_lat0: got %b required 0", valid_tx); end
        tests_run++; if (pkt_count !== 10'd1) begin tests_failed++; $display("FAIL basic_pkt1: got %0d required 1", pkt_count); end
        @(negedge clk);
        tests_run++; if (valid_tx !== 1'b0) begin tests_failed++; $display("FAIL basic_lat1: got %b required 0", valid_tx); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cur = {payload_tx, first_tx, last_tx, last_be_tx};
            tests_run++;
            if (valid_tx !== 1'b1 || cur !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL basic_word%0d: got v=%b %h required v=1 %h", i, valid_tx, cur, exp_w[i]);
            end
        end
        @(negedge clk);
        ready_tx = 1'b0;
        tests_run++; if (valid_tx !== 1'b0) begin tests_failed++; $display("FAIL basic_end_valid: got %b required 0", valid_tx); end
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL basic_pkt0: got %0d required 0", pkt_count); end
    endtask

    task automatic test_back_to_back();
        bit    c;
        int    cyc = 0;
        word_t cur;
        word_t e;
        do_reset();
        send_pkt(5, 4'b0001, 0, c);
        send_pkt(1, 4'b0111, 0, c);
        send_pkt(7, 4'b1000, 0, c);
        repeat (3) @(negedge clk);
        ready_tx = 1'b1;
        while (valid_tx !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 13; i++) begin
            cur = {payload_tx, first_tx, last_tx, last_be_tx};
            e   = exp_q.pop_front();
            tests_run++;
            if (valid_tx !== 1'b1 || cur !== e) begin
                tests_failed++;
                $display("FAIL b2b_word%0d: got v=%b %h required v=1 %h", i, valid_tx, cur, e);
            end
            @(negedge clk);
        end
        ready_tx = 1'b0;
        tests_run++; if (valid_tx !== 1'b0) begin tests_failed++; $display("FAIL b2b_end_valid: got %b required 0", valid_tx); end
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL b2b_pkt: got %0d required 0", pkt_count); end
    endtask

    task automatic test_fill_order();
        bit c;
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(100, 4'($urandom_range(1, 15)), 0, c);
        repeat (4) @(negedge clk);
        tests_run++; if (pkt_count !== 10'd4) begin tests_failed++; $display("FAIL fill_pkt4: got %0d required 4", pkt_count); end
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL fill_drop: got %0d required 0", drop_count); end
        drain(400, 1, 2000);
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL fill_pkt0: got %0d required 0", pkt_count); end
    endtask

    task automatic test_overflow();
        bit c;
        do_reset();
        for (int p = 0; p < 5; p++) send_pkt(100, 4'b1111, 0, c);
        send_pkt(20, 4'b0110, 0, c);
        repeat (3) @(negedge clk);
        tests_run++; if (drop_count !== 16'd1) begin tests_failed++; $display("FAIL ovf_drop: got %0d required 1", drop_count); end
        tests_run++; if (pkt_count !== 10'd5) begin tests_failed++; $display("FAIL ovf_pkt5: got %0d required 5", pkt_count); end
        tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL ovf_err: got %0d required 0", err_count); end
        drain(500, 2, 3000);
        send_pkt(10, 4'b0011, 0, c);
        repeat (4) @(negedge clk);
        tests_run++; if (pkt_count !== 10'd1) begin tests_failed++; $display("FAIL ovf_next_pkt: got %0d required 1", pkt_count); end
        drain(10, 0, 100);
        tests_run++; if (drop_count !== 16'd1) begin tests_failed++; $display("FAIL ovf_drop_end: got %0d required 1", drop_count); end
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL ovf_pkt0: got %0d required 0", pkt_count); end
    endtask

    task automatic test_framing();
        bit c;
        do_reset();
        for (int i = 0; i < 5; i++) drive_word(i == 0, 1'b0, $urandom, 4'hF);
        send_pkt(8, 4'b0111, 0, c);
        repeat (3) @(negedge clk);
        tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("FAIL frm_err1: got %0d required 1", err_count); end
        tests_run++; if (pkt_count !== 10'd1) begin tests_failed++; $display("FAIL frm_pkt1: got %0d required 1", pkt_count); end
        drain(8, 0, 100);
        for (int i = 0; i < 3; i++) drive_word(1'b0, i == 2, $urandom, 4'h1);
        send_pkt(6, 4'b0001, 0, c);
        repeat (3) @(negedge clk);
        tests_run++; if (err_count !== 16'd2) begin tests_failed++; $display("FAIL frm_err2: got %0d required 2", err_count); end
        drain(6, 0, 100);
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL frm_drop: got %0d required 0", drop_count); end
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL frm_pkt0: got %0d required 0", pkt_count); end
    endtask

    task automatic test_oversize();
        bit c;
        bit done = 1'b0;
        int seen = 0;
        do_reset();
        ready_tx = 1'b1;
        fork
            begin send_pkt(600, 4'b1111, 0, c); done = 1'b1; end
            begin
                while (!done) begin @(negedge clk); if (valid_tx) seen++; end
                repeat (5) begin @(negedge clk); if (valid_tx) seen++; end
            end
        join
        ready_tx = 1'b0;
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL big_valid: got %0d valid cycles required 0", seen); end
        tests_run++; if (drop_count !== 16'd1) begin tests_failed++; $display("FAIL big_drop: got %0d required 1", drop_count); end
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL big_pkt: got %0d required 0", pkt_count); end
        send_pkt(4, 4'b0011, 0, c);
        drain(4, 0, 100);
    endtask

    task automatic test_reset_mid_tx();
        bit    c;
        int    got = 0;
        int    cyc = 0;
        word_t cur;
        word_t e;
        do_reset();
        send_pkt(50, 4'b1100, 0, c);
        repeat (3) @(negedge clk);
        ready_tx = 1'b1;
        while (got < 10 && cyc < 100) begin
            if (valid_tx) begin
                cur = {payload_tx, first_tx, last_tx, last_be_tx};
                e   = exp_q.pop_front();
                tests_run++;
                if (cur !== e) begin tests_failed++; $display("FAIL midrst_word: got %h required %h", cur, e); end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if (valid_tx !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b required 0", valid_tx); end
        tests_run++; if (last_tx !== 1'b0) begin tests_failed++; $display("FAIL midrst_last: got %b required 0", last_tx); end
        tests_run++; if (payload_tx !== 32'h0) begin tests_failed++; $display("FAIL midrst_payload: got %h required 0", payload_tx); end
        tests_run++; if (last_be_tx !== 4'hF) begin tests_failed++; $display("FAIL midrst_be: got %h required f", last_be_tx); end
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL midrst_pkt: got %0d required 0", pkt_count); end
        tests_run++; if (ready_rx !== 1'b0) begin tests_failed++; $display("FAIL midrst_ready: got %b required 0", ready_rx); end
        rst = 1'b0; ready_tx = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        send_pkt(5, 4'b0101, 0, c);
        drain(5, 0, 100);
        tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL midrst_after: got %0d required 0", pkt_count); end
    endtask

    task automatic test_random();
        int lens[$];
        int total;
        bit c;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            lens.delete();
            total = 0;
            while (total <= 440) begin
                int l;
                l = int'($urandom_range(1, 40));
                lens.push_back(l);
                total += l;
            end
            fork
                begin foreach (lens[i]) send_pkt(lens[i], 4'($urandom_range(1, 15)), 30, c); end
                begin drain(total, 2, 8000); end
            join
            tests_run++; if (pkt_count !== 10'd0) begin tests_failed++; $display("FAIL rnd_pkt: got %0d required 0", pkt_count); end
        end
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL rnd_drop: got %0d required 0", drop_count); end
        tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL rnd_err: got %0d required 0", err_count); end
    endtask

    initial begin
        rst = 1'b1; valid_rx = 1'b0; first_rx = 1'b0; last_rx = 1'b0;
        payload_rx = '0; last_be_rx = '0; ready_tx = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_fill_order();
        test_overflow();
        test_framing();
        test_oversize();
        test_reset_mid_tx();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
